// File: rtl/spi_word_master.sv
// Memory-mapped SPI master (mode 0): a TXDATA store sends one 32-bit word as four
// MSB-first byte frames and packs the received bytes into RXDATA.
module spi_word_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        busy,
  output logic        done,
  output logic        mosi,
  input  logic        miso,
  output logic        ss,
  output logic        sck
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_DIV - 1);

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RXDATA = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [WORD_W-1:0]  tx_q, tx_d;
  logic [WORD_W-1:0]  rx_sh_q, rx_sh_d;
  logic [WORD_W-1:0]  rxdata_q, rxdata_d;
  logic               ovf_q, ovf_d;
  logic               rxv_q, rxv_d;
  logic               busy_d, done_d, mosi_d, ss_d, sck_d;
  logic               tx_wr, st_wr;

  // Next-state, datapath and next-output logic; every output is registered below.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    tx_d     = tx_q;
    rx_sh_d  = rx_sh_q;
    rxdata_d = rxdata_q;
    ovf_d    = ovf_q;
    rxv_d    = rxv_q;
    sck_d    = 1'b0;
    done_d   = 1'b0;
    tx_wr    = we && (addr == ADDR_TXDATA);
    st_wr    = we && (addr == ADDR_STATUS);

    if (st_wr) begin
      if (wd[1]) ovf_d = 1'b0;
      if (wd[2]) rxv_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (tx_wr) begin
          tx_d    = wd;
          state_d = SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // Low half then high half per bit; sample on the rise, advance on the fall.
        sck_d = sck;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[WORD_W-2:0], miso};
        end
        if (cnt_q == FULL_LAST) begin
          sck_d = 1'b0;
          cnt_d = '0;
          tx_d  = {tx_q[WORD_W-2:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (byte_q == 2'd3) ? DONE : GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q == FULL_LAST) begin
          state_d = SETUP;
          cnt_d   = '0;
          byte_d  = byte_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Completion sets rx_valid even against a same-cycle STATUS clear.
        state_d  = IDLE;
        done_d   = 1'b1;
        rxdata_d = rx_sh_q;
        rxv_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (tx_wr && (state_q != IDLE)) ovf_d = 1'b1;

    busy_d = (state_d != IDLE);
    ss_d   = !((state_d == SETUP) || (state_d == SHIFT));
    mosi_d = ss_d ? 1'b0 : tx_d[WORD_W-1];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tx_q     <= '0;
      rx_sh_q  <= '0;
      rxdata_q <= '0;
      ovf_q    <= 1'b0;
      rxv_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mosi     <= 1'b0;
      ss       <= 1'b1;
      sck      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
      rx_sh_q  <= rx_sh_d;
      rxdata_q <= rxdata_d;
      ovf_q    <= ovf_d;
      rxv_q    <= rxv_d;
      busy     <= busy_d;
      done     <= done_d;
      mosi     <= mosi_d;
      ss       <= ss_d;
      sck      <= sck_d;
    end
  end

  // Bus read mux; TXDATA is write-only and the reserved slot reads zero.
  always_comb begin
    rd = '0;
    case (addr)
      ADDR_STATUS: rd = {29'd0, rxv_q, ovf_q, busy};
      ADDR_RXDATA: rd = rxdata_q;
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_word_master.sv
// Directed bench for spi_word_master: SPI slave model returning 8'haa per byte,
// optional mosi->miso loopback, hand-computed expectations.
module tb_spi_word_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int          LAT     = 74 * CLK_DIV + 1;
  localparam logic [7:0]  S_WD    = 8'haa;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        busy, done, mosi, miso, ss, sck;
  logic        loopback;

  int checks = 0;
  int errors = 0;

  // Slave model state
  logic [7:0] s_out = 8'h00;
  logic [7:0] s_rx  = 8'h00;
  int         s_cnt = 0;
  int         rises = 0;
  logic       ss_l  = 1'b1;
  logic       sck_l = 1'b0;
  logic [7:0] got[$];
  int         done_cnt = 0;

  spi_word_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .rd   (rd),
    .busy (busy),
    .done (done),
    .mosi (mosi),
    .miso (miso),
    .ss   (ss),
    .sck  (sck)
  );

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : s_out[7];

  // Mode-0 slave: load on ss fall, capture mosi on sck rise, shift out on sck fall.
  always @(ss or sck) begin
    if (ss_l && !ss) begin
      s_out = S_WD;
      s_cnt = 0;
    end
    if (!sck_l && sck) begin
      s_rx = {s_rx[6:0], mosi};
      s_cnt++;
      rises++;
      if (s_cnt == 8) begin
        got.push_back(s_rx);
        s_cnt = 0;
      end
    end else if (sck_l && !sck) begin
      s_out = {s_out[6:0], 1'b0};
    end
    ss_l  = ss;
    sck_l = sck;
  end

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wd = d;
    @(posedge clk);
    #1;
    we = 1'b0; addr = 2'd0; wd = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1;
    d = rd;
  endtask

  task automatic wait_done(output int n);
    logic found;
    found = 1'b0;
    n = 0;
    while (!found && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (done) found = 1'b1;
    end
    check("done_within_budget", 32'(found), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [31:0] w);
    logic [31:0] tmp;
    check({tag, "_nbytes"}, 32'(got.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      tmp = w;
      if (got.size() > base + i)
        check({tag, "_byte"}, 32'(got[base + i]), 32'(tmp[31 - 8*i -: 8]));
    end
  endtask

  initial begin
    logic [31:0] r;
    int n, gbase, rbase, dbase;

    rst = 1'b1; we = 1'b0; addr = 2'd0; wd = 32'd0; loopback = 1'b0;
    #2 rst = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), r);
      check("rst_rd", r, 32'd0);
    end
    @(negedge clk) rst = 1'b1;

    // Basic word against the slave model
    gbase = got.size(); rbase = rises; dbase = done_cnt;
    bus_write(2'd0, 32'hdeadc0de);
    check("basic_busy_next", 32'(busy), 32'd1);
    check("basic_ss_low", 32'(ss), 32'd0);
    check("basic_mosi_msb", 32'(mosi), 32'd1);
    wait_done(n);
    check("basic_latency", 32'(n), 32'(LAT));
    check("basic_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("basic_done_cleared", 32'(done), 32'd0);
    check("basic_done_pulses", 32'(done_cnt - dbase), 32'd1);
    check("basic_rises", 32'(rises - rbase), 32'd32);
    check_bytes("basic", gbase, 32'hdeadc0de);
    bus_read(2'd2, r);
    check("basic_rxdata", r, 32'haaaaaaaa);
    bus_read(2'd1, r);
    check("basic_status", r, 32'h4);
    bus_read(2'd3, r);
    check("basic_reserved", r, 32'h0);

    // Loopback
    loopback = 1'b1;
    bus_write(2'd0, 32'hc001beef);
    wait_done(n);
    loopback = 1'b0;
    bus_read(2'd2, r);
    check("loop_rxdata", r, 32'hc001beef);
    bus_read(2'd1, r);
    check("loop_status", r, 32'h4);

    // Overrun: second write mid-transfer is dropped
    gbase = got.size();
    bus_write(2'd0, 32'hdeadbeef);
    repeat (99) @(posedge clk);
    bus_write(2'd0, 32'h12345678);
    bus_read(2'd1, r);
    check("ovf_status_busy", r, 32'h7);
    wait_done(n);
    check_bytes("ovf", gbase, 32'hdeadbeef);
    bus_read(2'd2, r);
    check("ovf_rxdata", r, 32'haaaaaaaa);
    bus_read(2'd1, r);
    check("ovf_status_done", r, 32'h6);
    bus_write(2'd1, 32'h6);
    bus_read(2'd1, r);
    check("ovf_status_cleared", r, 32'h0);

    // rx_valid clear in the DONE cycle loses to the set
    bus_write(2'd0, 32'h0000_00ff);
    repeat (LAT - 1) @(posedge clk);
    bus_write(2'd1, 32'h4);
    check("clr_race_done", 32'(done), 32'd1);
    bus_read(2'd1, r);
    check("clr_race_status", r, 32'h4);

    // TXDATA write in the DONE cycle is ignored and flags overrun
    bus_write(2'd0, 32'h0000_00ff);
    repeat (LAT - 1) @(posedge clk);
    bus_write(2'd0, 32'h5555_5555);
    check("done_wr_done", 32'(done), 32'd1);
    check("done_wr_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("done_wr_ss_idle", 32'(ss), 32'd1);
    bus_read(2'd1, r);
    check("done_wr_status", r, 32'h6);

    // Back-to-back: new word right after done
    bus_write(2'd1, 32'h6);
    bus_write(2'd0, 32'ha5a50f0f);
    wait_done(n);
    check("b2b_first_latency", 32'(n), 32'(LAT));
    gbase = got.size(); rbase = rises;
    bus_write(2'd0, 32'h3c9601fe);
    check("b2b_ss_low", 32'(ss), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b_latency", 32'(n), 32'(LAT));
    check("b2b_rises", 32'(rises - rbase), 32'd32);
    check_bytes("b2b", gbase, 32'h3c9601fe);
    bus_read(2'd1, r);
    check("b2b_status", r, 32'h4);

    // Mid-transfer reset during byte 2
    bus_write(2'd0, 32'h12345678);
    repeat (160) @(posedge clk); #1;
    check("mid_ss_active", 32'(ss), 32'd0);
    dbase = done_cnt;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ss", 32'(ss), 32'd1);
    check("mid_rst_sck", 32'(sck), 32'd0);
    check("mid_rst_mosi", 32'(mosi), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (400) @(posedge clk); #1;
    check("mid_no_done", 32'(done_cnt - dbase), 32'd0);
    bus_read(2'd2, r);
    check("mid_rxdata", r, 32'h0);
    bus_read(2'd1, r);
    check("mid_status", r, 32'h0);

    gbase = got.size();
    bus_write(2'd0, 32'h80000000);
    wait_done(n);
    check("post_latency", 32'(n), 32'(LAT));
    check_bytes("post", gbase, 32'h80000000);
    bus_read(2'd2, r);
    check("post_rxdata", r, 32'haaaaaaaa);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
